// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, widths and defaults for the boot loader writer.
package loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_REQ, S_ACKW, S_DONE} state_t;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int SEL_W  = WORD_W / BYTE_W;
    localparam logic [WORD_W-1:0] DEF_BASE_ADDR = 32'h0000_0000;
    localparam int DEF_IDLE_TIMEOUT = 200_000_000;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: little-endian byte-to-word packing with a one-entry holding register for bus-phase bytes.
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_clear,
    input  logic              i_collect,
    input  logic              i_bus,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_byte,
    output logic              o_full,
    output logic              o_partial,
    output logic              o_hold_valid,
    output logic              o_overrun,
    output logic [WORD_W-1:0] o_data,
    output logic [SEL_W-1:0]  o_sel
);
    logic [1:0]        r_idx;
    logic [WORD_W-1:0] r_data;
    logic [SEL_W-1:0]  r_sel;
    logic [BYTE_W-1:0] r_hold;
    logic              r_hold_v;
    logic              r_overrun;
    logic              w_pack;
    logic [BYTE_W-1:0] w_byte;

    // a held byte always goes in before the byte arriving in the same cycle
    assign w_pack       = i_collect && (r_hold_v || i_push);
    assign w_byte       = r_hold_v ? r_hold : i_byte;
    assign o_full       = w_pack && (r_idx == 2'd3);
    assign o_partial    = r_idx != 2'd0;
    assign o_hold_valid = r_hold_v;
    assign o_overrun    = r_overrun;
    assign o_data       = r_data;
    assign o_sel        = r_sel;

    always_ff @(posedge clk) begin
        if (!rst_n || i_start) begin
            r_idx     <= '0;
            r_data    <= '0;
            r_sel     <= '0;
            r_hold    <= '0;
            r_hold_v  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_clear) begin
                r_idx  <= '0;
                r_data <= '0;
                r_sel  <= '0;
            end else if (w_pack) begin
                r_data[{r_idx, 3'b000} +: BYTE_W] <= w_byte;
                r_sel[r_idx]                      <= 1'b1;
                r_idx                             <= r_idx + 2'd1;
            end
            if (i_collect) begin
                r_hold_v <= r_hold_v && i_push;
                if (r_hold_v && i_push)
                    r_hold <= i_byte;
            end else if (i_bus && i_push) begin
                if (r_hold_v)
                    r_overrun <= 1'b1;
                else begin
                    r_hold   <= i_byte;
                    r_hold_v <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/boot_writer_wb.sv
// boot_writer_wb: Wishbone master writing the UART byte stream as words into instruction memory.
module boot_writer_wb
    import loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter int                IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              uart_rx_irq,
    input  logic [BYTE_W-1:0] uart_rx_byte,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [WORD_W-1:0] wb_adr_o,
    output logic [WORD_W-1:0] wb_dat_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    input  logic              wb_stall_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              overrun_o,
    output logic [WORD_W-1:0] word_count_o
);
    state_t            r_state;
    logic              r_cyc, r_stb, r_busy, r_done, r_err, r_flush;
    logic [WORD_W-1:0] r_addr, r_count, r_timer;
    logic              w_full, w_partial, w_hold_v, w_timeout, w_ack, w_start;

    assign w_start = (r_state == S_IDLE) && start_i;
    assign w_ack   = (r_state == S_ACKW) && wb_ack_i && !wb_err_i;
    // a pending held byte is packed first, so it can never be skipped by a timeout
    assign w_timeout = (r_state == S_COLLECT) && (r_timer == 32'(IDLE_TIMEOUT - 1))
                       && !uart_rx_irq && !w_hold_v;

    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_stb;
    assign wb_we_o      = r_cyc;
    assign wb_adr_o     = r_addr;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign word_count_o = r_count;

    byte_packer u_packer (
        .clk          (wb_clk_i),
        .rst_n        (wb_rst_i),
        .i_start      (w_start),
        .i_clear      (w_ack),
        .i_collect    (r_state == S_COLLECT),
        .i_bus        (r_state == S_REQ || r_state == S_ACKW),
        .i_push       (uart_rx_irq),
        .i_byte       (uart_rx_byte),
        .o_full       (w_full),
        .o_partial    (w_partial),
        .o_hold_valid (w_hold_v),
        .o_overrun    (overrun_o),
        .o_data       (wb_dat_o),
        .o_sel        (wb_sel_o)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_flush <= 1'b0;
            r_addr  <= '0;
            r_count <= '0;
            r_timer <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_state <= S_COLLECT;
                    r_busy  <= 1'b1;
                    r_err   <= 1'b0;
                    r_flush <= 1'b0;
                    r_addr  <= BASE_ADDR;
                    r_count <= '0;
                    r_timer <= '0;
                end
                S_COLLECT: begin
                    r_timer <= uart_rx_irq ? '0 : r_timer + 32'd1;
                    if (w_full || (w_timeout && w_partial)) begin
                        r_state <= S_REQ;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_flush <= !w_full;
                        r_timer <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_timer <= '0;
                    end
                end
                S_REQ: if (!wb_stall_i) begin
                    r_state <= S_ACKW;
                    r_stb   <= 1'b0;
                end
                S_ACKW: if (wb_err_i) begin
                    r_state <= S_DONE;
                    r_cyc   <= 1'b0;
                    r_done  <= 1'b1;
                    r_err   <= 1'b1;
                end else if (wb_ack_i) begin
                    r_state <= r_flush ? S_DONE : S_COLLECT;
                    r_cyc   <= 1'b0;
                    r_done  <= r_flush;
                    r_addr  <= r_addr + 32'd4;
                    r_count <= r_count + 32'd1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_boot_writer_wb.sv
// tb_boot_writer_wb: directed scenario bench for the boot loader Wishbone writer.
module tb_boot_writer_wb;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, irq = 1'b0;
    logic        stall = 1'b0, ack = 1'b0, err_in = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        cyc, stb, we, busy, done, err_o, ovr;
    logic [31:0] adr, dat, cnt;
    logic [3:0]  sel;
    logic        w_cyc, w_stb, w_we, w_busy, w_done, w_err, w_ovr;
    logic [31:0] w_adr, w_dat, w_cnt;
    logic [3:0]  w_sel;
    int          checks = 0, errors = 0, n;
    bit          ok, seen;

    boot_writer_wb #(.BASE_ADDR(32'h0000_0000), .IDLE_TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .start_i(start), .uart_rx_irq(irq), .uart_rx_byte(rx_byte),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_dat_o(dat), .wb_sel_o(sel),
        .wb_stall_i(stall), .wb_ack_i(ack), .wb_err_i(err_in), .busy_o(busy), .done_o(done),
        .err_o(err_o), .overrun_o(ovr), .word_count_o(cnt)
    );

    boot_writer_wb #(.BASE_ADDR(32'hFFFF_FFFC), .IDLE_TIMEOUT(8)) dut_w (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .start_i(start), .uart_rx_irq(irq), .uart_rx_byte(rx_byte),
        .wb_cyc_o(w_cyc), .wb_stb_o(w_stb), .wb_we_o(w_we), .wb_adr_o(w_adr), .wb_dat_o(w_dat), .wb_sel_o(w_sel),
        .wb_stall_i(stall), .wb_ack_i(ack), .wb_err_i(err_in), .busy_o(w_busy), .done_o(w_done),
        .err_o(w_err), .overrun_o(w_ovr), .word_count_o(w_cnt)
    );

    always #5 clk = ~clk;

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        irq = 1'b1;
        rx_byte = b;
        @(negedge clk);
        irq = 1'b0;
    endtask

    task automatic wait_stb(output bit found);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (stb) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic respond(input int stalls, input bit e);
        stall = 1'b1;
        repeat (stalls) @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        if (e) err_in = 1'b1;
        else ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        err_in = 1'b0;
    endtask

    task automatic wait_done(output int pulses, input int cycles);
        pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({cyc, stb, we, busy, done, err_o, ovr} !== 7'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 0000000", {cyc, stb, we, busy, done, err_o, ovr}); end
        checks++; if ({adr, dat, sel} !== 68'h0) begin errors++; $display("FAIL reset_bus got adr %h dat %h sel %h exp 0", adr, dat, sel); end
        checks++; if (cnt !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp 0", cnt); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_word();
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b exp 1", busy); end
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        checks++; if ({cyc, stb, we} !== 3'b111) begin errors++; $display("FAIL full_ctrl got %b exp 111", {cyc, stb, we}); end
        checks++; if (adr !== 32'h0 || dat !== 32'h13 || sel !== 4'hF) begin errors++; $display("FAIL full_req got adr %h dat %h sel %h exp 0 13 f", adr, dat, sel); end
        stall = 1'b0;
        @(negedge clk);
        checks++; if ({cyc, stb} !== 2'b10) begin errors++; $display("FAIL full_stb_once got %b exp 10", {cyc, stb}); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++; if (adr !== 32'h4 || cnt !== 32'h1 || cyc !== 1'b0) begin errors++; $display("FAIL full_ack got adr %h cnt %h cyc %b exp 4 1 0", adr, cnt, cyc); end
        wait_done(n, 20);
        checks++; if (n != 1) begin errors++; $display("FAIL full_done_pulses got %0d exp 1", n); end
        checks++; if (cnt !== 32'h1 || busy !== 1'b0) begin errors++; $display("FAIL full_end got cnt %h busy %b exp 1 0", cnt, busy); end
    endtask

    task automatic test_flush();
        pulse_start();
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        wait_stb(ok);
        checks++; if (!ok || adr !== 32'h0 || dat !== 32'h04030201 || sel !== 4'hF) begin errors++; $display("FAIL flush_w1 got ok %b adr %h dat %h sel %h exp 1 0 04030201 f", ok, adr, dat, sel); end
        respond(3, 1'b0);
        send_byte(8'h05); send_byte(8'h06);
        wait_stb(ok);
        checks++; if (!ok || adr !== 32'h4 || dat !== 32'h00000605 || sel !== 4'h3) begin errors++; $display("FAIL flush_w2 got ok %b adr %h dat %h sel %h exp 1 4 00000605 3", ok, adr, dat, sel); end
        respond(3, 1'b0);
        checks++; if (done !== 1'b1 || cnt !== 32'h2) begin errors++; $display("FAIL flush_done got done %b cnt %h exp 1 2", done, cnt); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL flush_idle got done %b busy %b ovr %b exp 0 0 0", done, busy, ovr); end
    endtask

    task automatic test_bus_phase();
        pulse_start();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        checks++; if (stb !== 1'b1 || dat !== 32'hDDCCBBAA) begin errors++; $display("FAIL bp_w1 got stb %b dat %h exp 1 ddccbbaa", stb, dat); end
        stall = 1'b0;
        @(negedge clk);
        irq = 1'b1; rx_byte = 8'h11; ack = 1'b1;
        @(negedge clk);
        irq = 1'b0; ack = 1'b0;
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_stb(ok);
        checks++; if (!ok || dat !== 32'h44332211 || adr !== 32'h4) begin errors++; $display("FAIL bp_held got ok %b dat %h adr %h exp 1 44332211 4", ok, dat, adr); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL bp_no_overrun got %b exp 0", ovr); end
        stall = 1'b1; irq = 1'b1; rx_byte = 8'h55;
        @(negedge clk);
        rx_byte = 8'h66;
        @(negedge clk);
        irq = 1'b0; stall = 1'b0;
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b exp 1", ovr); end
        send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
        wait_stb(ok);
        checks++; if (!ok || dat !== 32'h99887755 || adr !== 32'h8) begin errors++; $display("FAIL bp_drop got ok %b dat %h adr %h exp 1 99887755 8", ok, dat, adr); end
        respond(0, 1'b0);
        checks++; if (cnt !== 32'h3) begin errors++; $display("FAIL bp_count got %h exp 3", cnt); end
        wait_done(n, 20);
        checks++; if (n != 1 || ovr !== 1'b1) begin errors++; $display("FAIL bp_end got pulses %0d ovr %b exp 1 1", n, ovr); end
    endtask

    task automatic test_bus_error();
        pulse_start();
        checks++; if (ovr !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL err_start_clear got ovr %b err %b exp 0 0", ovr, err_o); end
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        wait_stb(ok);
        respond(0, 1'b1);
        checks++; if (!ok || done !== 1'b1 || cyc !== 1'b0 || err_o !== 1'b1 || cnt !== 32'h0) begin errors++; $display("FAIL err_resp got ok %b done %b cyc %b err %b cnt %h exp 1 1 0 1 0", ok, done, cyc, err_o, cnt); end
        checks++; if (adr !== 32'h0) begin errors++; $display("FAIL err_addr got %h exp 0", adr); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || err_o !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL err_hold got busy %b err %b done %b exp 0 1 0", busy, err_o, done); end
        pulse_start();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err_o); end
        wait_done(n, 20);
        checks++; if (n != 1 || cnt !== 32'h0) begin errors++; $display("FAIL err_empty got pulses %0d cnt %h exp 1 0", n, cnt); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        checks++; if (stb !== 1'b1) begin errors++; $display("FAIL rstmid_req got %b exp 1", stb); end
        stall = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        stall = 1'b0;
        checks++; if ({cyc, stb, we, busy, done, w_cyc, w_stb} !== 7'b0) begin errors++; $display("FAIL rstmid_ctrl got %b exp 0000000", {cyc, stb, we, busy, done, w_cyc, w_stb}); end
        checks++; if (adr !== 32'h0 || cnt !== 32'h0 || sel !== 4'h0) begin errors++; $display("FAIL rstmid_regs got adr %h cnt %h sel %h exp 0 0 0", adr, cnt, sel); end
        rst_n = 1'b1;
        wait_done(n, 5);
        checks++; if (n != 0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_nodone got pulses %0d busy %b exp 0 0", n, busy); end
    endtask

    task automatic test_wrap();
        pulse_start();
        checks++; if (w_adr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_base got %h exp fffffffc", w_adr); end
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        wait_stb(ok);
        checks++; if (!ok || w_stb !== 1'b1 || w_adr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_w1 got ok %b stb %b adr %h exp 1 1 fffffffc", ok, w_stb, w_adr); end
        respond(0, 1'b0);
        checks++; if (w_adr !== 32'h0) begin errors++; $display("FAIL wrap_inc got %h exp 0", w_adr); end
        for (int i = 5; i <= 8; i++) send_byte(8'(i));
        wait_stb(ok);
        checks++; if (!ok || w_adr !== 32'h0 || w_dat !== 32'h08070605 || adr !== 32'h4) begin errors++; $display("FAIL wrap_w2 got ok %b adr %h dat %h adr0 %h exp 1 0 08070605 4", ok, w_adr, w_dat, adr); end
        respond(0, 1'b0);
        wait_done(n, 20);
        checks++; if (n != 1 || w_cnt !== 32'h2) begin errors++; $display("FAIL wrap_end got pulses %0d cnt %h exp 1 2", n, w_cnt); end
    endtask

    task automatic test_timeout_boundary();
        pulse_start();
        send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        seen = 1'b0;
        repeat (7) begin
            @(negedge clk);
            if (done || stb) seen = 1'b1;
        end
        send_byte(8'hC4);
        wait_stb(ok);
        checks++; if (seen || !ok || dat !== 32'hC4C3C2C1 || sel !== 4'hF) begin errors++; $display("FAIL tmo_restart got early %b ok %b dat %h sel %h exp 0 1 c4c3c2c1 f", seen, ok, dat, sel); end
        respond(0, 1'b0);
        seen = 1'b0;
        repeat (7) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL tmo_early got done before 8 idle cycles exp none"); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || cnt !== 32'h1) begin errors++; $display("FAIL tmo_fire got done %b cnt %h exp 1 1", done, cnt); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got busy %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_flush();
        test_bus_phase();
        test_bus_error();
        test_reset_mid();
        test_wrap();
        test_timeout_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/boot_writer_wb.md
# boot_writer_wb

Wishbone master that turns the UART byte stream into instruction-memory writes while the core is held in reset during programming mode. It packs received bytes little-endian into 32-bit words and writes them to consecutive word addresses from a base address. An idle timeout ends the session and flushes any partial word with the matching byte selects. It is started by the programming-mode controller and shares the memory port with the core through the existing bus mux.

## Interface
- BASE_ADDR, 32'h0000_0000: address of the first written word. Must be word-aligned.
- IDLE_TIMEOUT, 200000000: consecutive cycles without `uart_rx_irq` that end a session. Equals 2 s at 100 MHz. Must be ≥ 1.
- wb_clk_i  in  1  system clock. Single clock domain.
- wb_rst_i  in  1  reset. Synchronous, active-low.
- start_i  in  1  one-cycle pulse that begins a session. Ignored unless the block is in IDLE.
- uart_rx_irq  in  1  one-cycle strobe: `uart_rx_byte` is valid.
- uart_rx_byte  in  8  received byte.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  pipelined Wishbone master controls.
- wb_adr_o  out  32  byte address of the word being written.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  byte lane enables.
- wb_stall_i, wb_ack_i, wb_err_i  in  1 each  slave responses.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when a session ends.
- err_o  out  1  sticky bus error. Cleared by `start_i`.
- overrun_o  out  1  sticky byte-dropped flag. Cleared by `start_i`.
- word_count_o  out  32  words written in the current or last session. Wraps at 2^32.

## Operation
- States:
  - IDLE → COLLECT on `start_i`.
  - COLLECT → REQ when the 4th byte of a word arrives, or on timeout with 1–3 bytes held.
  - COLLECT → DONE on timeout with 0 bytes held.
  - REQ → ACKW when `wb_stall_i` is low.
  - ACKW → COLLECT on `wb_ack_i`, or → DONE if the write was a flush.
  - ACKW → DONE on `wb_err_i`, which also sets `err_o`.
  - DONE → IDLE after one cycle.
- Session start (`start_i` in IDLE) sets:
  - address = BASE_ADDR
  - byte index = 0
  - data and select = 0
  - `word_count_o` = 0
  - timer = 0
  - `err_o` and `overrun_o` cleared
- Byte packing: byte index k (0–3) goes to bits [8k+7:8k] and sets sel[k]. The first byte of each word lands in bits [7:0].
- Idle timer:
  - Counts cycles in COLLECT; cleared on each `uart_rx_irq`.
  - Timeout fires when the timer reaches IDLE_TIMEOUT−1 with no `uart_rx_irq` in that cycle.
- Bus writes:
  - `wb_we_o` = 1 for every write.
  - `wb_cyc_o` is high in REQ and ACKW. `wb_stb_o` is high only in REQ.
  - `wb_sel_o` = 4'b1111 for a full word; the accumulated select for a flush.
  - `wb_adr_o`, `wb_dat_o` and `wb_sel_o` stay stable from REQ entry until ACKW exit.
- On `wb_ack_i`:
  - address += 4, wrapping mod 2^32
  - `word_count_o` += 1; a flush counts as one word
  - data, select and byte index cleared
- On `wb_err_i`: address and count are unchanged; the session ends.
- Bytes arriving in REQ or ACKW:
  - The first is captured in a one-entry holding register.
  - A further byte while the register is full is dropped and sets `overrun_o`.
  - On return to COLLECT, the held byte is packed in the first cycle, before any new byte. A new `uart_rx_irq` in that same cycle refills the holding register.
- Bytes arriving in IDLE or DONE are ignored.
- A simultaneous `wb_ack_i` and `wb_err_i` is treated as an error.
- `wb_ack_i` or `wb_err_i` outside ACKW is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; internal registers 0. Reset asserted mid-transfer drops `wb_cyc_o` and `wb_stb_o` at the next edge. No `done_o` is produced.
- `start_i` at edge N → COLLECT and `busy_o` = 1 from N+1.
- 4th `uart_rx_irq` sampled at edge K → `wb_stb_o` = 1 from K+1.
- With `wb_stall_i` = 0, `wb_stb_o` is high for exactly one cycle.
- `wb_ack_i` sampled at edge A → COLLECT at A+1, with the incremented address already visible.
- Timeout edge T:
  - With 0 bytes held: DONE at T+1, `done_o` high during T+1, IDLE at T+2.
  - With 1–3 bytes held: flush REQ at T+1.
- After `done_o`, `word_count_o` and `err_o` hold until the next `start_i`.

## Structure
- Package `loader_pkg`:
  - state encoding constants (IDLE, COLLECT, REQ, ACKW, DONE)
  - byte and word width constants
  - default BASE_ADDR and IDLE_TIMEOUT
- Sub-module `byte_packer`:
  - byte index, data register, select register, one-entry holding register, overrun detect
  - interface: push, byte, clear, full, partial, data, sel
- The top level holds the FSM, timer, address and count registers, and the Wishbone drive.

## Test plan
- Full-word write: `start_i`, then bytes 0x13,0x00,0x00,0x00 → one write to 0x0000_0000 with dat 0x0000_0013, sel 4'hF. After timeout: `word_count_o` = 1, `done_o` pulses once.
- Flush write: 6 bytes 01..06, slave stalls 3 cycles on each write. Writes observed: 0x0 with 0x04030201, sel F; then 0x4 with 0x00000605, sel 4'b0011. `word_count_o` = 2.
- Bytes during the bus phase: one byte during ACKW → packed as the next word's byte 0, no overrun. Two bytes during ACKW → second dropped, `overrun_o` = 1.
- Bus error: slave asserts `wb_err_i` on the first write → `err_o` = 1, `done_o` pulses, `word_count_o` = 0, `wb_cyc_o` low the next cycle. The next `start_i` clears `err_o`.
- Reset and wrap: reset asserted during REQ → all outputs 0 next cycle, state IDLE. Separately, with BASE_ADDR = 32'hFFFF_FFFC, two words write to 0xFFFF_FFFC then 0x0000_0000.
- Timeout boundary (IDLE_TIMEOUT = 8): a byte arriving exactly IDLE_TIMEOUT−1 cycles after the previous one restarts the timer. No byte within 8 cycles → `done_o`.
